// File: rtl/fp32_pkg.sv
// Shared FP32 constants, converter state encoding and field packing helper.
package fp32_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } cvt_state_e;

  // Assemble {sign, exponent, fraction} into a single-precision word.
  function automatic logic [31:0] fp32_pack(input logic                   sign,
                                            input logic [FP32_EXP_W-1:0]  exp,
                                            input logic [FP32_FRAC_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/int_to_float32_if.sv
// Operand/result bundle for the integer-to-float stage (en/load/ready style).
interface int_to_float32_if;
  import fp32_pkg::*;

  logic        en;
  logic        load;
  logic        signed_in;
  logic [31:0] A;
  logic [31:0] result;
  logic        ready;
  logic        busy;
  logic        inexact;

  // Requester side: drives operands and control, observes the result.
  modport master (
    output en, load, signed_in, A,
    input  result, ready, busy, inexact
  );

  // Converter side.
  modport slave (
    input  en, load, signed_in, A,
    output result, ready, busy, inexact
  );
endinterface

// File: rtl/fp32_round_pack.sv
// Combinational round-to-nearest-even of a normalised 32-bit magnitude to a
// 24-bit significand, with carry-out renormalisation and FP32 packing.
module fp32_round_pack
  import fp32_pkg::*;
#(
  parameter int BIAS     = FP32_BIAS,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        sign_i,
  input  logic [31:0] mag_i,    // mag_i[31] is the hidden one
  input  logic [4:0]  shift_i,  // left shifts applied to reach mag_i
  output logic [31:0] result_o,
  output logic        inexact_o
);

  // Exponent of an unshifted bit 31; each normalising shift takes one off.
  localparam logic [FP32_EXP_W-1:0] EXP_TOP = FP32_EXP_W'(BIAS + 31);

  logic [23:0]             sig;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic [24:0]             sig_sum;
  logic [FP32_EXP_W-1:0]   exp_val;
  logic [FP32_FRAC_W-1:0]  frac_val;
  logic                    unused_hidden;

  // Round, renormalise on carry-out and pack the fields.
  always_comb begin
    sig      = mag_i[31:8];
    guard    = mag_i[7];
    sticky   = |mag_i[6:0];
    round_up = ROUND_EN && guard && (sticky || mag_i[8]);
    sig_sum  = {1'b0, sig} + {24'd0, round_up};
    exp_val  = EXP_TOP - FP32_EXP_W'(shift_i);
    frac_val = sig_sum[FP32_FRAC_W-1:0];
    // 0xFFFFFF + 1 carries out: significand becomes 1.0, exponent bumps.
    if (sig_sum[24]) begin
      frac_val = '0;
      exp_val  = exp_val + 8'd1;
    end
    result_o  = fp32_pack(sign_i, exp_val, frac_val);
    inexact_o = guard | sticky;
  end

  // Hidden bit is implied by normalisation and never stored.
  assign unused_hidden = sig_sum[23];

endmodule

// File: rtl/int_to_float32.sv
// Sequential int32/uint32 -> FP32 converter: negate to a magnitude, normalise
// one bit per cycle while counting leading zeros, then round and pack.
module int_to_float32
  import fp32_pkg::*;
#(
  parameter int BIAS     = FP32_BIAS,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  int_to_float32_if.slave  io
);

  cvt_state_e  state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [31:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        inexact_q, inexact_d;

  logic [31:0] rp_result;
  logic        rp_inexact;
  logic        in_sign;

  fp32_round_pack #(
    .BIAS     (BIAS),
    .ROUND_EN (ROUND_EN)
  ) u_round_pack (
    .sign_i    (sign_q),
    .mag_i     (mag_q),
    .shift_i   (cnt_q),
    .result_o  (rp_result),
    .inexact_o (rp_inexact)
  );

  assign in_sign = io.signed_in & io.A[31];

  // Next-state and datapath: accept loads when idle/done, normalise, round.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    result_d  = result_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    inexact_d = inexact_q;
    if (io.en) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (io.load) begin
            sign_d  = in_sign;
            // Signed 0x80000000 negates to itself, which is the right magnitude.
            mag_d   = in_sign ? (~io.A + 32'd1) : io.A;
            cnt_d   = '0;
            ready_d = 1'b0;
            busy_d  = 1'b1;
            state_d = NORM;
          end
        end
        NORM: begin
          if (mag_q == 32'd0) begin
            // Zero is always +0.0 and exact.
            result_d  = 32'h0000_0000;
            inexact_d = 1'b0;
            ready_d   = 1'b1;
            busy_d    = 1'b0;
            state_d   = DONE;
          end else if (mag_q[31]) begin
            state_d = ROUND;
          end else begin
            mag_d = {mag_q[30:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
          end
        end
        ROUND: begin
          result_d  = rp_result;
          inexact_d = rp_inexact;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; reset wins over en and load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      inexact_q <= inexact_d;
    end
  end

  assign io.result  = result_q;
  assign io.ready   = ready_q;
  assign io.busy    = busy_q;
  assign io.inexact = inexact_q;

endmodule

// File: tb/tb_int_to_float32.sv
// Scoreboard bench for int_to_float32: drivers push expected results, monitors
// pop and compare on each rising edge of ready.
module tb_int_to_float32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_to_float32_if io ();
  int_to_float32_if io2 ();

  int_to_float32 #(.BIAS(127), .ROUND_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int_to_float32 #(.BIAS(127), .ROUND_EN(1'b0)) dut_trunc (
    .clk (clk),
    .rst (rst),
    .io  (io2)
  );

  typedef struct {
    logic [31:0] res;
    logic        inx;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for the rounding DUT.
  logic rdy1_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (io.ready === 1'b1 && rdy1_prev !== 1'b1) begin
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %h, want no result", io.result);
      end else begin
        e = q1.pop_front();
        check("result", io.result, e.res);
        check("inexact", {31'd0, io.inexact}, {31'd0, e.inx});
        check("latency", 32'(cyc), 32'(e.due));
      end
    end
    rdy1_prev = io.ready;
  end

  // Monitor for the truncating DUT.
  logic rdy2_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (io2.ready === 1'b1 && rdy2_prev !== 1'b1) begin
      if (q2.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result_trunc: got %h, want no result", io2.result);
      end else begin
        e = q2.pop_front();
        check("trunc_result", io2.result, e.res);
        check("trunc_inexact", {31'd0, io2.inexact}, {31'd0, e.inx});
        check("trunc_latency", 32'(cyc), 32'(e.due));
      end
    end
    rdy2_prev = io2.ready;
  end

  // One conversion on the rounding DUT, optionally with an en stall or a
  // rejected load injected while busy. Returns once ready is seen.
  task automatic convert(input logic s, input logic [31:0] a, input logic [31:0] res,
                         input logic inx, input int lat, input int stall_at = -1,
                         input int stall_len = 0, input int ld_at = -1);
    int  busy_n;
    bit  done;
    @(negedge clk);
    io.load = 1'b1;
    io.signed_in = s;
    io.A = a;
    @(posedge clk);
    #1;
    io.load = 1'b0;
    q1.push_back('{res, inx, cyc + lat + stall_len});
    busy_n = 0;
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (io.busy === 1'b1) busy_n++;
      if (io.ready === 1'b1) done = 1'b1;
      if (k == stall_at) io.en = 1'b0;
      if (k == stall_at + stall_len) io.en = 1'b1;
      if (k == ld_at) begin
        io.load = 1'b1;
        io.signed_in = 1'b0;
        io.A = 32'h1234_5678;
      end
      if (k == ld_at + 1) io.load = 1'b0;
    end
    io.en = 1'b1;
    io.load = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got no ready for A=%h, want ready after %0d edges", a, lat + stall_len);
      if (q1.size() != 0) void'(q1.pop_front());
    end else begin
      check("busy_cycles", 32'(busy_n), 32'(lat + stall_len));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done2;
    rst = 1'b1;
    io.en = 1'b1;  io.load = 1'b0;  io.signed_in = 1'b0;  io.A = '0;
    io2.en = 1'b1; io2.load = 1'b0; io2.signed_in = 1'b0; io2.A = '0;
    repeat (2) @(negedge clk);
    check("reset_result", io.result, 32'h0);
    check("reset_flags", {29'd0, io.ready, io.busy, io.inexact}, 32'h0);
    rst = 1'b0;

    convert(1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33);
    convert(1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33);
    convert(1'b1, 32'h8000_0000, 32'hCF00_0000, 1'b0, 2);
    convert(1'b0, 32'h8000_0000, 32'h4F00_0000, 1'b0, 2);
    convert(1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b1, 9);
    convert(1'b0, 32'h0100_0003, 32'h4B80_0002, 1'b1, 9);
    convert(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1);
    convert(1'b0, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1, 2);
    convert(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1);
    convert(1'b1, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 3);
    convert(1'b1, 32'hFFFF_FFF6, 32'hC120_0000, 1'b0, 30);
    convert(1'b0, 32'h0000_0064, 32'h42C8_0000, 1'b0, 27);
    // en held low for 5 cycles mid-normalisation.
    convert(1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33, 10, 5);
    // A load while busy must be ignored.
    convert(1'b1, 32'hFFFF_FFF6, 32'hC120_0000, 1'b0, 30, -1, 0, 3);

    // Reset mid-normalisation, then a fresh conversion.
    @(negedge clk);
    io.load = 1'b1; io.signed_in = 1'b0; io.A = 32'h0000_0001;
    @(negedge clk);
    io.load = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_rst", {31'd0, io.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_result", io.result, 32'h0);
    check("rst_mid_flags", {29'd0, io.ready, io.busy, io.inexact}, 32'h0);
    convert(1'b0, 32'h0000_0064, 32'h42C8_0000, 1'b0, 27);

    // Truncation instance: 0xFFFFFFFF must not round up.
    @(negedge clk);
    io2.load = 1'b1; io2.signed_in = 1'b0; io2.A = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    io2.load = 1'b0;
    q2.push_back('{32'h4F7F_FFFF, 1'b1, cyc + 2});
    done2 = 1'b0;
    for (int k = 0; k < 10 && !done2; k++) begin
      @(negedge clk);
      if (io2.ready === 1'b1) done2 = 1'b1;
    end
    if (!done2) begin
      vectors++;
      miscompares++;
      $display("FAIL trunc_timeout: got no ready, want ready after 2 edges");
    end

    repeat (3) @(negedge clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
